if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
// - Instruction-fetch (IF) stage: owns the PC and drives the instruction SRAM request.
// - Produces if_to_id_bus {ce, pc} for the decode stage.
// - Consumes the decode stage's br_bus {br_e, br_addr}, and holds a branch redirect that arrives while IF is stalled.
// - Sits between the stall controller/inst SRAM and the ID stage. SRAM read latency is 1 cycle, so ID samples the returned word against this bus.
// PARAMETERS
// - RESET_PC  32'hBFC0_0000  address of the first instruction fetched after reset
// PORTS
// - clk              in   1             single clock, rising edge
// - rst              in   1             synchronous, active-high reset
// - stall            in   `StallBus     stall vector; bit0 = PC/IF stage, bit1 = IF/ID register
// - br_bus           in   `BR_WD        {br_e, br_addr[31:0]} from ID
// - if_to_id_bus     out  `IF_TO_ID_WD  {ce, pc[31:0]} to ID
// - inst_sram_en     out  1             fetch request enable
// - inst_sram_wen    out  4             byte write enables, always 4'b0
// - inst_sram_addr   out  32            fetch address (= pc)
// - inst_sram_wdata  out  32            always 32'b0
// BEHAVIOUR
// - State:
//   - pc_r[31:0], ce_r: the current fetch.
//   - redir_v, redir_addr[31:0]: the held redirect.
// - Reset (synchronous, rst=1 at posedge):
//   - pc_r <= RESET_PC - 4, ce_r <= 0, redir_v <= 0, redir_addr <= 0.
//   - While ce_r=0: inst_sram_en=0 and if_to_id_bus = {1'b0, RESET_PC-4}.
// - next_pc priority:
//   1. br_e=1 → br_addr
//   2. else redir_v=1 → redir_addr
//   3. else pc_r + 4 (mod 2^32, wrap at 32'hFFFF_FFFC → 0)
// - stall[0]==`NoStop at posedge:
//   - pc_r <= next_pc, ce_r <= 1, redir_v <= 0.
// - stall[0]==`Stop at posedge:
//   - pc_r and ce_r hold.
//   - If br_e=1: redir_v <= 1, redir_addr <= br_addr. A later br_e overwrites it; newest wins.
//   - If br_e=0: redir_v and redir_addr hold.
// - br_e and stall release in the same cycle: br_addr is taken directly and the held redirect is discarded.
// - Outputs are combinational from registers:
//   - inst_sram_en = ce_r, inst_sram_addr = pc_r, if_to_id_bus = {ce_r, pc_r}.
//   - Latency: PC update → SRAM request same cycle → data valid next cycle.
// - rst mid-stall or with redir_v=1: the reset values win and the held redirect is lost.
// - No flush port; ID squashes via its own stall/bubble rule.
// CONFIGURATION
// - Macro IF_ADEL_EN.
// - Defined:
//   - Adds output ports fetch_adel (1) and fetch_badvaddr (32).
//   - When ce_r=1 and pc_r[1:0]!=0: inst_sram_en=0, fetch_adel=1, fetch_badvaddr=pc_r, and the if_to_id_bus ce bit is forced 0.
//   - Otherwise fetch_adel=0 and fetch_badvaddr=0.
//   - Reset: fetch_adel=0, fetch_badvaddr=0.
// - Undefined:
//   - Neither port exists.
//   - A misaligned PC is fetched as-is with the address unchanged.
// STRUCTURE
// - Shared defines (lib/defines.vh): `StallBus, `BR_WD, `IF_TO_ID_WD, `Stop/`NoStop, and the reset-vector constant used as the RESET_PC default.
// - One sub-module: if_redirect_hold (redir_v/redir_addr capture and priority mux that produces next_pc).
// - PC register and output assignment stay in if_fetch.
// TESTING
// 1. rst for 2 cycles, then release with stall=0:
//    - During reset: ce=0, inst_sram_en=0.
//    - 1st post-reset cycle: pc=BFC0_0000, ce=1.
//    - Then BFC0_0004, BFC0_0008.
// 2. Running at pc=BFC0_0010, pulse br_e=1 with br_addr=BFC0_0100 for one cycle:
//    - Next cycle: pc=BFC0_0100.
//    - Then BFC0_0104.
// 3. stall[0]=Stop for 3 cycles at pc=BFC0_0020, with br_e=1 / br_addr=BFC0_0200 in the first stalled cycle:
//    - pc holds at BFC0_0020 during the stall.
//    - The cycle after release: pc=BFC0_0200, redir_v=0.
// 4. Same as 3 plus a second br_e with br_addr=BFC0_0300 while still stalled:
//    - After release: pc=BFC0_0300 (newest wins).
// 5. Held redirect to BFC0_0200, then release coinciding with br_e / br_addr=BFC0_0400:
//    - pc=BFC0_0400.
//    - redir_v cleared; BFC0_0200 is never fetched.
// 6. IF_ADEL_EN defined, br_addr=BFC0_0102:
//    - fetch_adel=1, fetch_badvaddr=BFC0_0102, inst_sram_en=0, ce out=0.
//    - Next cycle: pc=BFC0_0106, still flagged.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared widths, stall encodings and bus layouts for the instruction-fetch stage.
// Also holds the reset-vector constant that if_fetch uses as its default RESET_PC.
package if_fetch_pkg;

   localparam int STALL_BUS_W = 6;
   localparam int BR_WD       = 33;
   localparam int IF_TO_ID_WD = 33;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

   typedef enum logic {
      NO_STOP = 1'b0,
      STOP    = 1'b1
   } stop_e;

   typedef struct packed {
      logic        br_e;
      logic [31:0] br_addr;
   } br_bus_t;

   typedef struct packed {
      logic        ce;
      logic [31:0] pc;
   } if_to_id_t;

   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/if_redirect_hold.sv
// Captures a branch redirect that arrives while IF is stalled and picks next_pc.
// Priority: live branch, then held redirect, then sequential pc + 4.
module if_redirect_hold
   import if_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_pc,
   input  logic        br_e,
   input  logic [31:0] br_addr,
   input  logic [31:0] pc,
   output logic [31:0] next_pc
);

   logic        redir_v;
   logic [31:0] redir_addr;

   // A redirect seen during a stall is parked here; the newest one wins, and any
   // cycle where the PC advances consumes (or discards) whatever is parked.
   always_ff @(posedge clk) begin
      if (rst) begin
         redir_v    <= 1'b0;
         redir_addr <= 32'd0;
      end else if (stall_pc == NO_STOP) begin
         redir_v <= 1'b0;
      end else if (br_e) begin
         redir_v    <= 1'b1;
         redir_addr <= br_addr;
      end
   end

   always_comb begin
      next_pc = seq_pc(pc);
      if (br_e) begin
         next_pc = br_addr;
      end else if (redir_v) begin
         next_pc = redir_addr;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the inst SRAM request and the IF->ID bus.
// Define IF_ADEL_EN to add misaligned-fetch detection (fetch_adel / fetch_badvaddr).
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_VECTOR
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [STALL_BUS_W-1:0] stall,
   input  logic [BR_WD-1:0]       br_bus,
   output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
   output logic                   inst_sram_en,
   output logic [3:0]             inst_sram_wen,
   output logic [31:0]            inst_sram_addr,
   output logic [31:0]            inst_sram_wdata
`ifdef IF_ADEL_EN
   ,
   output logic                   fetch_adel,
   output logic [31:0]            fetch_badvaddr
`endif
);

   br_bus_t     br;
   if_to_id_t   to_id;
   logic [31:0] pc_r;
   logic        ce_r;
   logic [31:0] next_pc;
   logic        unused_stall;

   assign br           = br_bus_t'(br_bus);
   assign unused_stall = &{1'b0, stall[STALL_BUS_W-1:1]};

   if_redirect_hold u_redirect_hold (
      .clk      (clk),
      .rst      (rst),
      .stall_pc (stall[0]),
      .br_e     (br.br_e),
      .br_addr  (br.br_addr),
      .pc       (pc_r),
      .next_pc  (next_pc)
   );

   // Reset parks the PC one word before the vector so the first real fetch
   // lands exactly on RESET_PC with ce raised.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r <= RESET_PC - 32'd4;
         ce_r <= 1'b0;
      end else if (stall[0] == NO_STOP) begin
         pc_r <= next_pc;
         ce_r <= 1'b1;
      end
   end

`ifdef IF_ADEL_EN
   // A misaligned fetch is suppressed at the SRAM and reported as an address error.
   always_comb begin
      to_id          = '{ce: ce_r, pc: pc_r};
      inst_sram_en   = ce_r;
      fetch_adel     = 1'b0;
      fetch_badvaddr = 32'd0;
      if (ce_r && is_misaligned(pc_r)) begin
         to_id.ce       = 1'b0;
         inst_sram_en   = 1'b0;
         fetch_adel     = 1'b1;
         fetch_badvaddr = pc_r;
      end
   end
`else
   always_comb begin
      to_id        = '{ce: ce_r, pc: pc_r};
      inst_sram_en = ce_r;
   end
`endif

   assign if_to_id_bus    = to_id;
   assign inst_sram_wen   = 4'b0000;
   assign inst_sram_addr  = pc_r;
   assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed scenarios plus random stall/branch traffic.
// Build with IF_ADEL_EN defined to also exercise the misaligned-fetch reporting.
module tb_if_fetch;

   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   typedef struct {
      logic        ce;
      logic [31:0] pc;
      logic        en;
      logic        adel;
      logic [31:0] bad;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic [32:0] br_bus;
   logic [32:0] if_to_id_bus;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
`ifdef IF_ADEL_EN
   logic        fetch_adel;
   logic [31:0] fetch_badvaddr;
`endif

   exp_t        expQ[$];
   int          testsRun = 0;
   int          testsFailed = 0;

   // reference model state: the architectural PC and any parked redirect
   logic [31:0] mPc;
   logic        mCe;
   logic        mHasRedir;
   logic [31:0] mRedir;

   if_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .br_bus          (br_bus),
      .if_to_id_bus    (if_to_id_bus),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_wen   (inst_sram_wen),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata)
`ifdef IF_ADEL_EN
      ,
      .fetch_adel      (fetch_adel),
      .fetch_badvaddr  (fetch_badvaddr)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic exp_t modelOutputs();
      exp_t e;
      logic bad;
`ifdef IF_ADEL_EN
      bad = mCe && (mPc % 4 != 0);
`else
      bad = 1'b0;
`endif
      e.ce   = mCe && !bad;
      e.pc   = mPc;
      e.en   = mCe && !bad;
      e.adel = bad;
      e.bad  = bad ? mPc : 32'd0;
      return e;
   endfunction

   // Drive one cycle's inputs on the falling edge and queue what the DUT must show after the next rise.
   task automatic applyStimulus(input logic r, input logic [5:0] st, input logic be, input logic [31:0] ba);
      @(negedge clk);
      rst    = r;
      stall  = st;
      br_bus = {be, ba};
      if (r) begin
         mPc       = RST_PC - 32'd4;
         mCe       = 1'b0;
         mHasRedir = 1'b0;
         mRedir    = 32'd0;
      end else if (!st[0]) begin
         if (be)             mPc = ba;
         else if (mHasRedir) mPc = mRedir;
         else                mPc = 32'((64'(mPc) + 64'd4) % 64'h1_0000_0000);
         mCe       = 1'b1;
         mHasRedir = 1'b0;
      end else if (be) begin
         mHasRedir = 1'b1;
         mRedir    = ba;
      end
      expQ.push_back(modelOutputs());
   endtask

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
      testsRun++;
      if (act !== req) begin
         testsFailed++;
         $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      compare("ce", 32'(if_to_id_bus[32]), 32'(e.ce));
      compare("pc", if_to_id_bus[31:0], e.pc);
      compare("sram_en", 32'(inst_sram_en), 32'(e.en));
      compare("sram_addr", inst_sram_addr, e.pc);
      compare("sram_wen", 32'(inst_sram_wen), 32'd0);
      compare("sram_wdata", inst_sram_wdata, 32'd0);
`ifdef IF_ADEL_EN
      compare("fetch_adel", 32'(fetch_adel), 32'(e.adel));
      compare("fetch_badvaddr", fetch_badvaddr, e.bad);
`endif
   endtask

   // Directed spot-check of the IF->ID bus against a hand-written constant.
   task automatic checkPc(input string name, input logic ceReq, input logic [31:0] pcReq);
      @(posedge clk);
      #2;
      compare({name, "_ce"}, 32'(if_to_id_bus[32]), 32'(ceReq));
      compare({name, "_pc"}, if_to_id_bus[31:0], pcReq);
   endtask

   // Monitor: one output beat per clock, popped against the scoreboard.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) checkOutput(expQ.pop_front());
      end
   end

   initial begin
      rst    = 1'b1;
      stall  = 6'd0;
      br_bus = 33'd0;
      mPc = RST_PC - 32'd4; mCe = 1'b0; mHasRedir = 1'b0; mRedir = 32'd0;

      applyStimulus(1, 6'd0, 0, 32'd0);          checkPc("rst0", 0, 32'hBFBF_FFFC);
      applyStimulus(1, 6'd0, 0, 32'd0);          checkPc("rst1", 0, 32'hBFBF_FFFC);
      applyStimulus(0, 6'd0, 0, 32'd0);          checkPc("boot0", 1, 32'hBFC0_0000);
      applyStimulus(0, 6'd0, 0, 32'd0);          checkPc("boot1", 1, 32'hBFC0_0004);
      applyStimulus(0, 6'd0, 0, 32'd0);          checkPc("boot2", 1, 32'hBFC0_0008);
      applyStimulus(0, 6'd0, 0, 32'd0);
      applyStimulus(0, 6'd0, 0, 32'd0);          checkPc("run", 1, 32'hBFC0_0010);
      applyStimulus(0, 6'd0, 1, 32'hBFC0_0100);  checkPc("br", 1, 32'hBFC0_0100);
      applyStimulus(0, 6'd0, 0, 32'd0);          checkPc("br_seq", 1, 32'hBFC0_0104);

      applyStimulus(0, 6'd0, 1, 32'hBFC0_0020);
      applyStimulus(0, 6'd1, 1, 32'hBFC0_0200);  checkPc("hold0", 1, 32'hBFC0_0020);
      applyStimulus(0, 6'd1, 0, 32'd0);          checkPc("hold1", 1, 32'hBFC0_0020);
      applyStimulus(0, 6'd1, 0, 32'd0);          checkPc("hold2", 1, 32'hBFC0_0020);
      applyStimulus(0, 6'd0, 0, 32'd0);          checkPc("redir", 1, 32'hBFC0_0200);
      applyStimulus(0, 6'd0, 0, 32'd0);          checkPc("redir_seq", 1, 32'hBFC0_0204);

      applyStimulus(0, 6'd0, 1, 32'hBFC0_0020);
      applyStimulus(0, 6'd1, 1, 32'hBFC0_0200);
      applyStimulus(0, 6'd1, 1, 32'hBFC0_0300);
      applyStimulus(0, 6'd1, 0, 32'd0);
      applyStimulus(0, 6'd0, 0, 32'd0);          checkPc("newest", 1, 32'hBFC0_0300);

      applyStimulus(0, 6'd0, 1, 32'hBFC0_0020);
      applyStimulus(0, 6'd1, 1, 32'hBFC0_0200);
      applyStimulus(0, 6'd1, 0, 32'd0);
      applyStimulus(0, 6'd0, 1, 32'hBFC0_0400);  checkPc("live_br", 1, 32'hBFC0_0400);
      applyStimulus(0, 6'd0, 0, 32'd0);          checkPc("discard", 1, 32'hBFC0_0404);

      applyStimulus(0, 6'd1, 1, 32'hBFC0_0500);
      applyStimulus(1, 6'd1, 0, 32'd0);          checkPc("rst_stall", 0, 32'hBFBF_FFFC);
      applyStimulus(0, 6'd0, 0, 32'd0);          checkPc("reboot", 1, 32'hBFC0_0000);

      applyStimulus(0, 6'd0, 1, 32'hFFFF_FFFC);  checkPc("top", 1, 32'hFFFF_FFFC);
      applyStimulus(0, 6'd0, 0, 32'd0);          checkPc("wrap", 1, 32'h0000_0000);

`ifdef IF_ADEL_EN
      applyStimulus(0, 6'd0, 1, 32'hBFC0_0102);  checkPc("adel0", 0, 32'hBFC0_0102);
      compare("adel0_flag", 32'(fetch_adel), 32'd1);
      compare("adel0_bad", fetch_badvaddr, 32'hBFC0_0102);
      applyStimulus(0, 6'd0, 0, 32'd0);          checkPc("adel1", 0, 32'hBFC0_0106);
      compare("adel1_flag", 32'(fetch_adel), 32'd1);
`else
      applyStimulus(0, 6'd0, 1, 32'hBFC0_0102);  checkPc("misal0", 1, 32'hBFC0_0102);
      applyStimulus(0, 6'd0, 0, 32'd0);          checkPc("misal1", 1, 32'hBFC0_0106);
`endif

      for (int i = 0; i < 500; i++) begin
         logic        r;
         logic [5:0]  st;
         logic        be;
         logic [31:0] ba;
         r  = ($urandom_range(0, 39) == 0);
         st = 6'($urandom);
         st[0] = ($urandom_range(0, 9) < 3);
         be = ($urandom_range(0, 4) == 0);
         ba = $urandom;
         if ($urandom_range(0, 7) != 0) ba[1:0] = 2'b00;
         applyStimulus(r, st, be, ba);
      end

      repeat (3) @(posedge clk);
      #3;
      testsRun++;
      if (expQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL scoreboard_drain: actual=%0d required=0 pending", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
